// File: rtl/cpi_pixel_packer_if.sv
// ---------------------------------------------------------------------------
// cpi_pixel_packer_if
// Word bus between the CPI pixel packer and the uDMA RX linear channel.
//   data_rx_data_o     [31:0]  packed little-endian word (packer -> channel)
//   data_rx_valid_o            word available            (packer -> channel)
//   data_rx_datasize_o [1:0]   transfer size, 2'b10      (packer -> channel)
//   data_rx_ready_i            channel accepts the word  (channel -> packer)
// Modports: master = packer side, slave = RX channel side.
// ---------------------------------------------------------------------------
interface cpi_pixel_packer_if;
  logic [31:0] data_rx_data_o;
  logic        data_rx_valid_o;
  logic [1:0]  data_rx_datasize_o;
  logic        data_rx_ready_i;

  modport master (
    output data_rx_data_o,
    output data_rx_valid_o,
    output data_rx_datasize_o,
    input  data_rx_ready_i
  );

  modport slave (
    input  data_rx_data_o,
    input  data_rx_valid_o,
    input  data_rx_datasize_o,
    output data_rx_ready_i
  );
endinterface

// File: rtl/cpi_pixel_packer.sv
// ---------------------------------------------------------------------------
// cpi_pixel_packer
// Packs a synchronised camera pixel stream into 32-bit little-endian words,
// with frame delimiting, partial-word flush at end of frame and a small word
// FIFO for elasticity. The camera cannot be stalled, so dropped words set a
// sticky overflow flag instead.
//
// Ports:
//   sys_clk_i, rst_i      clock, asynchronous active-high reset
//   pix_data_i [9:0]      pixel sample, qualified by pix_valid_i
//   pix_valid_i           pixel present this cycle
//   sof_i / eof_i         first / last pixel of frame
//   cfg_en_i              packer enable (0 forces IDLE)
//   cfg_format_i [1:0]    0: [7:0], 1: [9:2], 2: 16-bit zero-extended, 3: as 0
//   cfg_clr_i             clears overflow_o (a simultaneous set wins)
//   rx                    word bus (master modport) toward the RX channel
//   frame_evt_o           one-cycle pulse after each accepted end of frame
//   overflow_o            sticky word-drop flag
//   frame_pix_cnt_o[23:0] pixels of current frame (only with CPI_PACKER_STATS_EN)
//
// Optional feature macro: CPI_PACKER_STATS_EN
// ---------------------------------------------------------------------------
module cpi_pixel_packer #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = 10
) (
  input  logic                  sys_clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] pix_data_i,
  input  logic                  pix_valid_i,
  input  logic                  sof_i,
  input  logic                  eof_i,
  input  logic                  cfg_en_i,
  input  logic [1:0]            cfg_format_i,
  input  logic                  cfg_clr_i,
  cpi_pixel_packer_if.master    rx,
  output logic                  frame_evt_o,
`ifdef CPI_PACKER_STATS_EN
  output logic [23:0]           frame_pix_cnt_o,
`endif
  output logic                  overflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SOF, S_ACTIVE} state_t;

  state_t       state_q, state_d;
  logic [1:0]   fmt_q, fmt_d;
  logic [31:0]  acc_q, acc_d;
  logic [1:0]   lane_q, lane_d;
  logic         evt_q, evt_d;
  logic         ovf_q, ovf_d;
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]  mem_q [FIFO_DEPTH];

  // Pixel acceptance: start opens a frame (also restarts on a missing EOF),
  // cont appends to the running frame.
  logic start, cont, take;
  assign start = cfg_en_i && pix_valid_i && sof_i &&
                 (state_q == S_WAIT_SOF || state_q == S_ACTIVE);
  assign cont  = cfg_en_i && pix_valid_i && !sof_i && (state_q == S_ACTIVE);
  assign take  = start || cont;

  logic [1:0]  fmt_eff;
  logic        is16;
  logic [1:0]  lane_base;
  logic [31:0] acc_base;
  logic [15:0] lane_val;
  logic [4:0]  shift;
  logic [31:0] word;
  logic        full_word;
  logic        push, pop, push_ok, fifo_empty, fifo_full;

  // ---------------- state register ----------------
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      fmt_q    <= 2'd0;
      acc_q    <= 32'd0;
      lane_q   <= 2'd0;
      evt_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 32'd0;
    end else begin
      state_q  <= state_d;
      fmt_q    <= fmt_d;
      acc_q    <= acc_d;
      lane_q   <= lane_d;
      evt_q    <= evt_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= word;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    if (!cfg_en_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:     state_d = S_WAIT_SOF;
        S_WAIT_SOF,
        S_ACTIVE:   if (take) state_d = eof_i ? S_WAIT_SOF : S_ACTIVE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // ---------------- datapath / outputs ----------------
  always_comb begin
    // A new frame uses the format presented with its SOF pixel; mid-frame
    // format changes are ignored until then.
    fmt_eff   = start ? ((cfg_format_i == 2'd3) ? 2'd0 : cfg_format_i) : fmt_q;
    is16      = (fmt_eff == 2'd2);
    lane_base = start ? 2'd0 : lane_q;
    acc_base  = start ? 32'd0 : acc_q;
    case (fmt_eff)
      2'd1:    lane_val = {8'd0, pix_data_i[9:2]};
      2'd2:    lane_val = {6'd0, pix_data_i};
      default: lane_val = {8'd0, pix_data_i[7:0]};
    endcase
    shift     = is16 ? {lane_base[0], 4'd0} : {lane_base, 3'd0};
    word      = acc_base | ({16'd0, lane_val} << shift);
    full_word = is16 ? lane_base[0] : (lane_base == 2'd3);
    push      = take && (full_word || eof_i);

    fmt_d  = fmt_q;
    acc_d  = acc_q;
    lane_d = lane_q;
    evt_d  = 1'b0;
    if (!cfg_en_i || state_q == S_IDLE) begin
      acc_d  = 32'd0;
      lane_d = 2'd0;
    end else if (take) begin
      fmt_d = fmt_eff;
      evt_d = eof_i;
      if (push) begin
        acc_d  = 32'd0;
        lane_d = 2'd0;
      end else begin
        acc_d  = word;
        lane_d = lane_base + 2'd1;
      end
    end

    // FIFO with an extra wrap bit on each pointer to tell full from empty.
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    pop        = !fifo_empty && rx.data_rx_ready_i;
    // A push into a full FIFO still fits if the head leaves in the same cycle.
    push_ok    = push && (!fifo_full || pop);
    wr_ptr_d   = wr_ptr_q + (PTR_W+1)'(push_ok);
    rd_ptr_d   = rd_ptr_q + (PTR_W+1)'(pop);

    if (push && !push_ok) ovf_d = 1'b1;
    else if (cfg_clr_i)   ovf_d = 1'b0;
    else                  ovf_d = ovf_q;
  end

  assign rx.data_rx_data_o     = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign rx.data_rx_valid_o    = !fifo_empty;
  assign rx.data_rx_datasize_o = 2'b10;
  assign frame_evt_o           = evt_q;
  assign overflow_o            = ovf_q;

`ifdef CPI_PACKER_STATS_EN
  logic [23:0] cnt_q, cnt_d;
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= 24'd0;
    else       cnt_q <= cnt_d;
  end
  always_comb begin
    cnt_d = cnt_q;
    if (start)                             cnt_d = 24'd1;
    else if (cont && cnt_q != 24'hFFFFFF)  cnt_d = cnt_q + 24'd1;
  end
  assign frame_pix_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_cpi_pixel_packer.sv
// ---------------------------------------------------------------------------
// tb_cpi_pixel_packer
// Directed bench for cpi_pixel_packer: 8-bit/upper-bit/16-bit packing,
// partial flush, format latching, overflow and clear, disable/resync and
// missing-EOF restart. Inputs change 1 ns after the rising edge; outputs are
// observed at the same point, i.e. they reflect the edge just taken.
// ---------------------------------------------------------------------------
module tb_cpi_pixel_packer;
  logic        sys_clk_i = 1'b0;
  logic        rst_i;
  logic [9:0]  pix_data_i;
  logic        pix_valid_i, sof_i, eof_i;
  logic        cfg_en_i, cfg_clr_i;
  logic [1:0]  cfg_format_i;
  logic        frame_evt_o, overflow_o;
`ifdef CPI_PACKER_STATS_EN
  logic [23:0] frame_pix_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  cpi_pixel_packer_if rx_if ();

  cpi_pixel_packer #(.FIFO_DEPTH(4), .DATA_WIDTH(10)) dut (
    .sys_clk_i    (sys_clk_i),
    .rst_i        (rst_i),
    .pix_data_i   (pix_data_i),
    .pix_valid_i  (pix_valid_i),
    .sof_i        (sof_i),
    .eof_i        (eof_i),
    .cfg_en_i     (cfg_en_i),
    .cfg_format_i (cfg_format_i),
    .cfg_clr_i    (cfg_clr_i),
    .rx           (rx_if.master),
    .frame_evt_o  (frame_evt_o),
`ifdef CPI_PACKER_STATS_EN
    .frame_pix_cnt_o (frame_pix_cnt_o),
`endif
    .overflow_o   (overflow_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk_i);
    #1;
  endtask

  // One pixel sampled at the next edge; back-to-back calls stream one per cycle.
  task automatic send(input logic [9:0] d, input logic s, input logic e);
    pix_data_i  = d;
    pix_valid_i = 1'b1;
    sof_i       = s;
    eof_i       = e;
    tick();
    pix_valid_i = 1'b0;
    sof_i       = 1'b0;
    eof_i       = 1'b0;
  endtask

  // Check the head word, then pop it.
  task automatic pop_chk(input string tag, input logic [31:0] exp);
    chk({tag, "_valid"}, {31'd0, rx_if.data_rx_valid_o}, 32'd1);
    chk({tag, "_data"}, rx_if.data_rx_data_o, exp);
    rx_if.data_rx_ready_i = 1'b1;
    tick();
    rx_if.data_rx_ready_i = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_word;

    rst_i = 1'b1;
    pix_data_i = '0; pix_valid_i = 0; sof_i = 0; eof_i = 0;
    cfg_en_i = 0; cfg_clr_i = 0; cfg_format_i = 2'd0;
    rx_if.data_rx_ready_i = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_valid", {31'd0, rx_if.data_rx_valid_o}, 32'd0);
    chk("rst_data", rx_if.data_rx_data_o, 32'd0);
    chk("rst_evt", {31'd0, frame_evt_o}, 32'd0);
    chk("rst_ovf", {31'd0, overflow_o}, 32'd0);
    chk("rst_datasize", {30'd0, rx_if.data_rx_datasize_o}, 32'd2);
`ifdef CPI_PACKER_STATS_EN
    chk("rst_cnt", {8'd0, frame_pix_cnt_o}, 32'd0);
`endif

    rst_i = 1'b0;
    cfg_en_i = 1'b1;
    tick();

    // 8-bit packing, format 0
    send(10'h011, 1, 0); send(10'h022, 0, 0); send(10'h033, 0, 0);
    chk("fmt0_no_word_yet", {31'd0, rx_if.data_rx_valid_o}, 32'd0);
    send(10'h044, 0, 1);
    chk("fmt0_evt", {31'd0, frame_evt_o}, 32'd1);
`ifdef CPI_PACKER_STATS_EN
    chk("fmt0_cnt", {8'd0, frame_pix_cnt_o}, 32'd4);
`endif
    pop_chk("fmt0_word", 32'h44332211);
    chk("fmt0_evt_end", {31'd0, frame_evt_o}, 32'd0);
    chk("fmt0_empty", {31'd0, rx_if.data_rx_valid_o}, 32'd0);

    // 16-bit with partial flush
    cfg_format_i = 2'd2;
    send(10'h3FF, 1, 0); send(10'h001, 0, 0); send(10'h155, 0, 1);
    chk("fmt2_evt", {31'd0, frame_evt_o}, 32'd1);
    pop_chk("fmt2_word0", 32'h000103FF);
    pop_chk("fmt2_word1", 32'h00000155);
    chk("fmt2_empty", {31'd0, rx_if.data_rx_valid_o}, 32'd0);

    // Upper-bits format; format change after SOF must not take effect
    cfg_format_i = 2'd1;
    send(10'h3FC, 1, 0);
    cfg_format_i = 2'd2;
    send(10'h004, 0, 0); send(10'h008, 0, 0); send(10'h00C, 0, 1);
    pop_chk("fmt1_word", 32'h030201FF);

    // Reserved format 3 behaves as format 0; single-pixel frame
    cfg_format_i = 2'd3;
    send(10'h3AB, 1, 1);
    chk("single_evt", {31'd0, frame_evt_o}, 32'd1);
    pop_chk("fmt3_single", 32'h000000AB);

    // Overflow: 5 full words with ready low, depth 4
    cfg_format_i = 2'd0;
    for (int i = 0; i < 20; i++) begin
      send(10'(i + 1), i == 0, i == 19);
      if (i == 15) chk("ovf_before", {31'd0, overflow_o}, 32'd0);
    end
    chk("ovf_set", {31'd0, overflow_o}, 32'd1);
    chk("ovf_evt", {31'd0, frame_evt_o}, 32'd1);
    cfg_clr_i = 1'b1;
    tick();
    cfg_clr_i = 1'b0;
    chk("ovf_clr", {31'd0, overflow_o}, 32'd0);
    for (int w = 0; w < 4; w++) begin
      exp_word = {8'(4*w + 4), 8'(4*w + 3), 8'(4*w + 2), 8'(4*w + 1)};
      pop_chk($sformatf("ovf_drain%0d", w), exp_word);
    end
    chk("ovf_drained", {31'd0, rx_if.data_rx_valid_o}, 32'd0);

    // Disable mid-frame, re-enable, non-SOF pixel ignored
    send(10'h0AA, 1, 0); send(10'h0BB, 0, 0);
    cfg_en_i = 1'b0;
    tick();
    cfg_en_i = 1'b1;
    tick();
    send(10'h0CC, 0, 0);
    chk("dis_no_word", {31'd0, rx_if.data_rx_valid_o}, 32'd0);
    send(10'h001, 1, 0); send(10'h002, 0, 0); send(10'h003, 0, 0); send(10'h004, 0, 1);
    pop_chk("dis_resync", 32'h04030201);
    chk("dis_empty", {31'd0, rx_if.data_rx_valid_o}, 32'd0);

    // Missing EOF: second SOF restarts the frame
    send(10'h010, 1, 0); send(10'h020, 0, 0); send(10'h030, 1, 0);
    chk("miss_no_evt", {31'd0, frame_evt_o}, 32'd0);
    chk("miss_no_word", {31'd0, rx_if.data_rx_valid_o}, 32'd0);
`ifdef CPI_PACKER_STATS_EN
    chk("miss_cnt_restart", {8'd0, frame_pix_cnt_o}, 32'd1);
`endif
    send(10'h040, 0, 0); send(10'h050, 0, 0); send(10'h060, 0, 1);
    chk("miss_evt", {31'd0, frame_evt_o}, 32'd1);
`ifdef CPI_PACKER_STATS_EN
    chk("miss_cnt", {8'd0, frame_pix_cnt_o}, 32'd4);
`endif
    pop_chk("miss_word", 32'h60504030);
    chk("miss_empty", {31'd0, rx_if.data_rx_valid_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
